// File: rtl/cubic_pkg.sv
// cubic_pkg: shared width, FSM state type and default timeout for cubic_dispatch
package cubic_pkg;
    localparam int DATA_W      = 8;
    localparam int TIMEOUT_DEF = 64;
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, RUN, HOLD} state_t;
endpackage

// File: rtl/cubic_dispatch_if.sv
// cubic_dispatch_if: request, root-unit and result signals of cubic_dispatch
// slave = dispatcher side, master = environment side; out_err exists only with CUBIC_DISPATCH_TIMEOUT_EN
interface cubic_dispatch_if;
    import cubic_pkg::*;
    logic              in_valid, in_ready, root_start, root_busy, out_valid, out_ready;
    logic [DATA_W-1:0] in_data, root_x, root_y, out_x, out_y;
`ifdef CUBIC_DISPATCH_TIMEOUT_EN
    logic              out_err;
`endif
    modport slave (
        input  in_valid, in_data, root_busy, root_y, out_ready,
        output in_ready, root_start, root_x, out_valid, out_x, out_y
`ifdef CUBIC_DISPATCH_TIMEOUT_EN
        , output out_err
`endif
    );
    modport master (
        output in_valid, in_data, root_busy, root_y, out_ready,
        input  in_ready, root_start, root_x, out_valid, out_x, out_y
`ifdef CUBIC_DISPATCH_TIMEOUT_EN
        , input out_err
`endif
    );
endinterface

// File: rtl/cubic_fifo.sv
// cubic_fifo: DEPTH-entry request FIFO (push/pop, full/empty/count), show-ahead head on o_data
module cubic_fifo
    import cubic_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_data,
    output logic              o_full,
    output logic              o_empty,
    output logic [CW-1:0]     o_count
);
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr, r_rd;
    logic [CW-1:0]     r_cnt;
    logic              w_push, w_pop;
    assign o_full  = r_cnt == CW'(DEPTH);
    assign o_empty = r_cnt == '0;
    assign o_count = r_cnt;
    assign o_data  = r_mem[r_rd];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    always_ff @(posedge clk)
        if (w_push) r_mem[r_wr] <= i_data;
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            r_wr  <= w_push ? r_wr + AW'(1) : r_wr;
            r_rd  <= w_pop ? r_rd + AW'(1) : r_rd;
            r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
        end
endmodule

// File: rtl/cubic_dispatch.sv
// cubic_dispatch: queues operands and feeds them one at a time to a cube-root unit, returning (x, y) in order
// ports: clk, reset (async active-low), bus (cubic_dispatch_if.slave); CUBIC_DISPATCH_TIMEOUT_EN adds a busy timeout and out_err
module cubic_dispatch
    import cubic_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = TIMEOUT_DEF,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    cubic_dispatch_if.slave  bus
);
    if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 2) begin : g_bad_param
        $error("cubic_dispatch: illegal DEPTH or TIMEOUT");
    end
    state_t            r_state, w_next;
    logic [DATA_W-1:0] r_op, r_out_x, r_out_y, w_head;
    logic [CW-1:0]     w_count;
    logic              r_out_valid, w_full, w_empty, w_pop, w_done, w_fail, w_tmo, w_ack;
    cubic_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (bus.in_valid && !w_full),
        .i_pop   (w_pop),
        .i_data  (bus.in_data),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );
    assign bus.in_ready   = w_count != CW'(DEPTH);
    assign bus.root_start = r_state == ISSUE;
    assign bus.root_x     = r_op;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_x      = r_out_x;
    assign bus.out_y      = r_out_y;
    assign w_pop  = r_state == IDLE && !w_empty;
    assign w_done = r_state == RUN && !bus.root_busy;
    assign w_fail = w_tmo && !w_done;
    assign w_ack  = r_state == HOLD && bus.out_ready;
`ifdef CUBIC_DISPATCH_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] r_tmo;
    logic          r_err, w_waiting;
    assign w_waiting   = r_state == WAIT_BUSY || r_state == RUN;
    assign w_tmo       = w_waiting && r_tmo == TW'(TIMEOUT - 1);
    assign bus.out_err = r_err;
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            r_tmo <= '0;
            r_err <= 1'b0;
        end else begin
            r_tmo <= w_waiting ? r_tmo + TW'(1) : '0;
            r_err <= (w_done || w_fail) ? w_fail : w_ack ? 1'b0 : r_err;
        end
`else
    assign w_tmo = 1'b0;
`endif
    always_ff @(posedge clk or negedge reset)
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:      w_next = w_empty ? IDLE : ISSUE;
            ISSUE:     w_next = WAIT_BUSY;
            WAIT_BUSY: w_next = w_tmo ? HOLD : bus.root_busy ? RUN : WAIT_BUSY;
            RUN:       w_next = (w_done || w_tmo) ? HOLD : RUN;
            HOLD:      w_next = bus.out_ready ? IDLE : HOLD;
            default:   w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            r_op        <= '0;
            r_out_valid <= 1'b0;
            r_out_x     <= '0;
            r_out_y     <= '0;
        end else begin
            if (w_pop) r_op <= w_head;
            if (w_done || w_fail) begin
                r_out_valid <= 1'b1;
                r_out_x     <= r_op;
                r_out_y     <= w_done ? bus.root_y : '1;
            end else if (w_ack) begin
                r_out_valid <= 1'b0;
            end
        end
endmodule

// File: tb/tb_cubic_dispatch.sv
// tb_cubic_dispatch: directed self-checking bench for cubic_dispatch with a behavioural cube-root unit
module tb_cubic_dispatch;
    import cubic_pkg::*;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   stuck = 1'b0;
    int   m_cnt = 0;
    always #5 clk = ~clk;
    cubic_dispatch_if bus ();
    cubic_dispatch #(.DEPTH(4), .TIMEOUT(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );
    function automatic logic [7:0] cbrt(input logic [7:0] x);
        logic [7:0] r = 0;
        for (int i = 0; i <= 6; i++) if (i * i * i <= int'(x)) r = 8'(i);
        return r;
    endfunction
    // root unit: busy rises the cycle after start and stays high 10 cycles (forever while stuck)
    always @(posedge clk or negedge reset)
        if (!reset) begin
            bus.root_busy <= 1'b0;
            bus.root_y    <= '0;
            m_cnt         <= 0;
        end else if (bus.root_start) begin
            bus.root_busy <= 1'b1;
            bus.root_y    <= cbrt(bus.root_x);
            m_cnt         <= 10;
        end else if (m_cnt > 0 && !stuck) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) bus.root_busy <= 1'b0;
        end
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic wait_out(input string tag);
        int n = 0;
        while (bus.out_valid !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        chk(tag, 32'(bus.out_valid), 1);
    endtask
    task automatic push(input logic [7:0] d);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        tick();
        bus.in_valid = 1'b0;
    endtask
    initial begin
        logic [7:0] vals [5] = '{8'd64, 8'd125, 8'd0, 8'd255, 8'd99};
        logic [7:0] xs [4]   = '{8'd64, 8'd125, 8'd0, 8'd255};
        logic [7:0] ys [4]   = '{8'd4, 8'd5, 8'd0, 8'd6};
        int seen_v, seen_s, n;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        repeat (3) tick();
        chk("rst_in_ready", 32'(bus.in_ready), 1);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_root_start", 32'(bus.root_start), 0);
        chk("rst_root_x", 32'(bus.root_x), 0);
        chk("rst_out_x", 32'(bus.out_x), 0);
        chk("rst_out_y", 32'(bus.out_y), 0);
`ifdef CUBIC_DISPATCH_TIMEOUT_EN
        chk("rst_out_err", 32'(bus.out_err), 0);
`endif
        reset = 1'b1;
        tick();
        push(8'd27);
        chk("lat_c1_start", 32'(bus.root_start), 0);
        tick();
        chk("lat_c2_start", 32'(bus.root_start), 1);
        chk("lat_c2_root_x", 32'(bus.root_x), 27);
        tick();
        chk("lat_c3_start", 32'(bus.root_start), 0);
        wait_out("t27_valid");
        chk("t27_x", 32'(bus.out_x), 27);
        chk("t27_y", 32'(bus.out_y), 3);
        tick();
        chk("t27_valid_drop", 32'(bus.out_valid), 0);
        bus.out_ready = 1'b0;
        push(8'd8);
        wait_out("t8_valid");
        for (int i = 0; i < 20; i++) begin
            bus.in_valid = i < 5;
            bus.in_data  = i < 5 ? vals[i] : 8'd0;
            chk("hold_in_ready", 32'(bus.in_ready), (i < 4) ? 1 : 0);
            chk("hold_valid", 32'(bus.out_valid), 1);
            chk("hold_x", 32'(bus.out_x), 8);
            chk("hold_y", 32'(bus.out_y), 2);
            chk("hold_no_start", 32'(bus.root_start), 0);
            tick();
        end
        bus.in_valid = 1'b0;
        chk("full_in_ready", 32'(bus.in_ready), 0);
        bus.out_ready = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            wait_out("seq_valid");
            chk("seq_x", 32'(bus.out_x), 32'(xs[k]));
            chk("seq_y", 32'(bus.out_y), 32'(ys[k]));
            tick();
        end
        seen_v = 0;
        repeat (30) begin
            if (bus.out_valid) seen_v++;
            tick();
        end
        chk("full_push_ignored", seen_v, 0);
        chk("drain_in_ready", 32'(bus.in_ready), 1);
        push(8'd1);
        push(8'd8);
        push(8'd27);
        n = 0;
        while (bus.root_busy !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("rst_run_busy", 32'(bus.root_busy), 1);
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(bus.out_valid), 0);
        chk("mid_rst_in_ready", 32'(bus.in_ready), 1);
        chk("mid_rst_start", 32'(bus.root_start), 0);
        chk("mid_rst_root_x", 32'(bus.root_x), 0);
        tick();
        reset = 1'b1;
        seen_v = 0;
        seen_s = 0;
        repeat (40) begin
            if (bus.out_valid) seen_v++;
            if (bus.root_start) seen_s++;
            tick();
        end
        chk("post_rst_no_valid", seen_v, 0);
        chk("post_rst_no_start", seen_s, 0);
        chk("post_rst_in_ready", 32'(bus.in_ready), 1);
        push(8'd125);
        wait_out("recover_valid");
        chk("recover_x", 32'(bus.out_x), 125);
        chk("recover_y", 32'(bus.out_y), 5);
        tick();
`ifdef CUBIC_DISPATCH_TIMEOUT_EN
        stuck = 1'b1;
        push(8'd200);
        wait_out("tmo_valid");
        chk("tmo_err", 32'(bus.out_err), 1);
        chk("tmo_y", 32'(bus.out_y), 32'hFF);
        chk("tmo_x", 32'(bus.out_x), 200);
        stuck = 1'b0;
        tick();
        chk("tmo_err_clear", 32'(bus.out_err), 0);
        chk("tmo_valid_clear", 32'(bus.out_valid), 0);
        push(8'd64);
        wait_out("after_tmo_valid");
        chk("after_tmo_err", 32'(bus.out_err), 0);
        chk("after_tmo_x", 32'(bus.out_x), 64);
        chk("after_tmo_y", 32'(bus.out_y), 4);
        tick();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/cubic_dispatch.md
CUBIC_DISPATCH -- requirements
Module: cubic_dispatch

Interface
REQ-001 SHALL have parameter DEPTH, default 4, request FIFO depth; power of two, 2..16.
REQ-002 SHALL have parameter TIMEOUT, default 64, max root-unit busy cycles; used only with CUBIC_DISPATCH_TIMEOUT_EN.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  request operand valid.
REQ-006 SHALL have port in_data  input  8  unsigned operand x.
REQ-007 SHALL have port in_ready  output  1  FIFO can accept.
REQ-008 SHALL have port root_start  output  1  one-cycle start pulse to cubic-root unit.
REQ-009 SHALL have port root_x  output  8  operand to cubic-root unit.
REQ-010 SHALL have port root_busy  input  1  cubic-root unit busy.
REQ-011 SHALL have port root_y  input  8  cubic-root unit result.
REQ-012 SHALL have port out_valid  output  1  result valid.
REQ-013 SHALL have port out_x  output  8  operand belonging to result.
REQ-014 SHALL have port out_y  output  8  floor cube root of out_x.
REQ-015 SHALL have port out_ready  input  1  consumer accepts result.

Function
REQ-016 SHALL push in_data when in_valid && in_ready; in_ready = (count != DEPTH), derived from registered count only.
REQ-017 SHALL use FSM states IDLE, ISSUE, WAIT_BUSY, RUN, HOLD.
REQ-018 IDLE: if FIFO non-empty, pop head into op register -> ISSUE; else stay.
REQ-019 ISSUE: root_start=1 for exactly this cycle, root_x=op -> WAIT_BUSY.
REQ-020 WAIT_BUSY: root_start=0; on root_busy=1 -> RUN.
REQ-021 RUN: on root_busy=0, capture root_y into out_y, op into out_x, assert out_valid -> HOLD.
REQ-022 HOLD: hold out_valid, out_x, out_y stable until out_valid && out_ready, then -> IDLE, deassert out_valid next cycle.
REQ-023 Latency: push in cycle 0 into empty FIFO, idle FSM -> pop cycle 1, root_start cycle 2.
REQ-024 Simultaneous push and pop SHALL leave count unchanged; pointers wrap modulo DEPTH.
REQ-025 Push when full SHALL be impossible (in_ready=0); in_data ignored.
REQ-026 Results SHALL leave in request order; only one operation outstanding at the root unit.
REQ-027 root_x SHALL hold op from ISSUE until the next ISSUE.

Reset
REQ-028 reset low SHALL immediately clear: state=IDLE, FIFO count/pointers=0, root_start=0, root_x=0, out_valid=0, out_x=0, out_y=0; in_ready=1 after release.
REQ-029 Reset mid-operation SHALL discard FIFO contents and any in-flight result; no out_valid pulse follows.

Configuration
REQ-030 With CUBIC_DISPATCH_TIMEOUT_EN defined: output port out_err (1 bit); a counter runs in WAIT_BUSY and RUN; at TIMEOUT cycles FSM SHALL go to HOLD with out_err=1, out_y=8'hFF.
REQ-031 out_err SHALL be 0 on normal completion and SHALL clear with out_valid.
REQ-032 Without the macro: no out_err port, no counter, FSM waits indefinitely.

Structure
REQ-033 Package cubic_pkg SHALL hold DATA_W=8, the FSM state typedef, and the default TIMEOUT constant.
REQ-034 FIFO SHALL be sub-module cubic_fifo (parameter DEPTH, push/pop/full/empty/count); FSM stays in cubic_dispatch.

Verification (behavioural root model: busy rises 1 cycle after start, falls after 10 cycles)
REQ-035 Push 27, out_ready=1 -> root_start pulse 2 cycles after push; out_valid with out_x=27, out_y=3.
REQ-036 Push 64,125,0,255 back-to-back, out_ready=0 -> in_ready=0 after 4 pushes; release out_ready -> outputs (64,4),(125,5),(0,0),(255,6) in order.
REQ-037 Hold out_ready=0 for 20 cycles in HOLD -> out_x/out_y stable, no new root_start.
REQ-038 Assert reset low during RUN with 2 queued -> no out_valid afterwards, in_ready=1, no root_start until new push.
REQ-039 With CUBIC_DISPATCH_TIMEOUT_EN, TIMEOUT=16, model busy stuck high -> out_valid with out_err=1, out_y=8'hFF; next request completes with out_err=0.
